riscv_stream_port: RTL and testbench
====================================

Name: riscv_stream_port

Overview:
- Bridges the picorv32 native memory bus to one inbound and one outbound 32-bit val/ack stream pair of the leaf_interface user side.
- Instantiated once per stream port inside picorv32_wrapper, directly downstream of the leaf_interface (dinN/val_inN/ready_upwardN) and upstream of it (doutN/val_outN/ready_downwardN).
- Each direction has a FIFO, so the CPU reads and writes streams as blocking memory-mapped registers.

Parameters:
- PAYLOAD_BITS, 32, stream word width; must equal 32.
- DEPTH, 8, entries per FIFO; power of two, minimum 2.
- BASE_ADDR, 32'h1000_0000, byte address of the 16-byte register window; must be 16-byte aligned.

Ports:
- clk  in  1  user clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset; driven by ap_start & !reset.
- mem_valid  in  1  CPU request valid; held until mem_ready.
- mem_addr  in  32  CPU byte address.
- mem_wdata  in  32  CPU write data.
- mem_wstrb  in  4  byte strobes; nonzero means write, zero means read.
- mem_ready  out  1  one-cycle request completion pulse.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- sel  out  1  high while mem_addr hits the window; wrapper uses it for rdata muxing.
- din  in  32  inbound stream data.
- val_in  in  1  inbound valid.
- ready_upward  out  1  inbound ack/ready.
- dout  out  32  outbound stream data.
- val_out  out  1  outbound valid.
- ready_downward  in  1  outbound ack from interface.

Behaviour:
- Reset, asynchronous on resetn low:
  - mem_ready=0, mem_rdata=0, ready_upward=0, val_out=0, dout=0.
  - Both FIFOs empty, FSM in IDLE.
  - A reset in the middle of a request or transfer discards FIFO contents and any pending request.
- Window decode: sel = mem_valid & (mem_addr[31:4] == BASE_ADDR[31:4]). Offset = mem_addr[3:2].
- Register map:
  - Offset 0, RX_DATA (R): pops the RX FIFO head.
  - Offset 1, TX_DATA (W): pushes mem_wdata into the TX FIFO. mem_wstrb content is ignored; any nonzero strobe writes the full word.
  - Offset 2, STATUS (R), non-blocking: {16'b0, tx_count[7:0], rx_count[7:0]}, counts zero-extended.
  - Offset 3: reads return 0, writes are dropped, always acked.
  - Reads of TX_DATA return 0. Writes to RX_DATA or STATUS are dropped. Both are acked.
- FSM states:
  - IDLE:
    - If sel and the access can complete, perform the action that cycle and go to RESP.
    - RX_DATA read with RX empty: stay in IDLE (CPU stalls) until the FIFO is non-empty.
    - TX_DATA write with TX full: stay in IDLE (CPU stalls) until space frees.
  - RESP: mem_ready=1 for exactly one cycle, mem_rdata holds the registered result, mem_valid is ignored; then return to IDLE.
  - Latency is 2 cycles from mem_valid to mem_ready when the access is immediately serviceable.
  - A new request presented in the cycle right after RESP is evaluated normally.
- RX FIFO:
  - Push when val_in & ready_upward.
  - ready_upward is registered: next value = (rx_count_next <= DEPTH-1). It is 0 while resetn is low and rises the first clock after release.
  - A push is therefore never issued while full.
  - Push and pop in the same cycle leave the count unchanged and are both legal, including at count=DEPTH with the pop.
- TX FIFO:
  - val_out = !tx_empty and dout = head, both taken from registers; the output is first-word-fall-through.
  - Pop on val_out & ready_downward.
  - Push from the CPU and pop from the stream in the same cycle are both legal.
  - A CPU push while full is impossible because the request stalls.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits.
- Data order: strict FIFO in both directions. No word is dropped or duplicated.

Test Plan:
- Reset, then release resetn: all outputs 0 during reset. ready_upward=1 one cycle after release. STATUS read returns 32'h0 with mem_ready 2 cycles after mem_valid.
- Stream in 0xA0..0xA7 (8 words, DEPTH=8) with no CPU reads:
  - ready_upward drops after the 8th accept.
  - STATUS = 32'h0000_0008.
  - 8 RX_DATA reads return 0xA0..0xA7 in order, and ready_upward reasserts after the first pop.
- Read RX_DATA with RX empty: mem_ready stays 0 for 20 cycles. Push 0x1234_5678 on din; mem_ready pulses within 2 cycles with rdata 0x1234_5678.
- Write TX_DATA 0xB0..0xB8 (9 writes) with ready_downward=0:
  - The 9th write stalls.
  - Raise ready_downward for one cycle: dout=0xB0 pops and the 9th write completes.
  - Remaining output order is 0xB1..0xB8.
- Run simultaneous RX push/pop and TX push/pop every cycle for 64 words with random ready_downward/val_in: scoreboard shows in-order, lossless data in both directions and counts never exceed 8.
- Additional accesses:
  - Access at BASE_ADDR+0x20: sel=0 and no mem_ready.
  - Access at offset 3: acked with rdata 0.
  - Assert resetn low mid-stall: mem_ready=0 and FIFOs empty after release.

Source files
------------

// File: rtl/riscv_stream_port.sv
// riscv_stream_port: maps one inbound and one outbound 32-bit val/ack stream
// onto a 16-byte picorv32 register window, with a FIFO in each direction.
module riscv_stream_port #(
   parameter int unsigned PAYLOAD_BITS = 32,
   parameter int unsigned DEPTH        = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    mem_valid,
   input  logic [31:0]             mem_addr,
   input  logic [31:0]             mem_wdata,
   input  logic [3:0]              mem_wstrb,
   output logic                    mem_ready,
   output logic [31:0]             mem_rdata,
   output logic                    sel,
   input  logic [PAYLOAD_BITS-1:0] din,
   input  logic                    val_in,
   output logic                    ready_upward,
   output logic [PAYLOAD_BITS-1:0] dout,
   output logic                    val_out,
   input  logic                    ready_downward
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   localparam logic [1:0] OFS_RX     = 2'd0;
   localparam logic [1:0] OFS_TX     = 2'd1;
   localparam logic [1:0] OFS_STATUS = 2'd2;

   typedef enum logic {ST_IDLE, ST_RESP} state_e;

   state_e                  state_q, state_d;
   logic                    mem_ready_q, mem_ready_d;
   logic [31:0]             mem_rdata_q, mem_rdata_d;

   logic [PAYLOAD_BITS-1:0] rx_mem [DEPTH];
   logic [PTR_W-1:0]        rx_rd_ptr_q, rx_rd_ptr_d;
   logic [PTR_W-1:0]        rx_wr_ptr_q, rx_wr_ptr_d;
   logic [CNT_W-1:0]        rx_count_q, rx_count_d;
   logic                    ready_upward_q, ready_upward_d;

   logic [PAYLOAD_BITS-1:0] tx_mem [DEPTH];
   logic [PTR_W-1:0]        tx_rd_ptr_q, tx_rd_ptr_d;
   logic [PTR_W-1:0]        tx_wr_ptr_q, tx_wr_ptr_d;
   logic [CNT_W-1:0]        tx_count_q, tx_count_d;
   logic                    val_out_q, val_out_d;
   logic [PAYLOAD_BITS-1:0] dout_q, dout_d;

   logic                    hit_c;
   logic                    is_write_c;
   logic [1:0]              offset_c;
   logic                    rx_push_c, rx_pop_c;
   logic                    tx_push_c, tx_pop_c;
   logic [31:0]             status_c;
   logic                    unused_c;

   // Window decode and request classification
   assign hit_c      = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign offset_c   = mem_addr[3:2];
   assign is_write_c = |mem_wstrb;
   assign status_c   = {16'b0, 8'(tx_count_q), 8'(rx_count_q)};
   assign unused_c   = ^mem_addr[1:0];

   // Bus FSM: perform the access in IDLE when it can complete, pulse ready in RESP
   always_comb begin
      state_d     = state_q;
      mem_ready_d = 1'b0;
      mem_rdata_d = mem_rdata_q;
      rx_pop_c    = 1'b0;
      tx_push_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hit_c) begin
               case (offset_c)
                  OFS_RX: begin
                     if (is_write_c) begin
                        state_d     = ST_RESP;
                        mem_ready_d = 1'b1;
                        mem_rdata_d = 32'h0;
                     end else if (rx_count_q != CNT_W'(0)) begin
                        rx_pop_c    = 1'b1;
                        state_d     = ST_RESP;
                        mem_ready_d = 1'b1;
                        mem_rdata_d = 32'(rx_mem[rx_rd_ptr_q]);
                     end
                  end
                  OFS_TX: begin
                     if (!is_write_c) begin
                        state_d     = ST_RESP;
                        mem_ready_d = 1'b1;
                        mem_rdata_d = 32'h0;
                     end else if (tx_count_q != FULL_CNT) begin
                        tx_push_c   = 1'b1;
                        state_d     = ST_RESP;
                        mem_ready_d = 1'b1;
                        mem_rdata_d = 32'h0;
                     end
                  end
                  OFS_STATUS: begin
                     state_d     = ST_RESP;
                     mem_ready_d = 1'b1;
                     mem_rdata_d = is_write_c ? 32'h0 : status_c;
                  end
                  default: begin
                     state_d     = ST_RESP;
                     mem_ready_d = 1'b1;
                     mem_rdata_d = 32'h0;
                  end
               endcase
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // RX FIFO bookkeeping; ready_upward looks at next-cycle occupancy
   always_comb begin
      rx_push_c      = val_in && ready_upward_q;
      rx_wr_ptr_d    = rx_wr_ptr_q + PTR_W'(rx_push_c);
      rx_rd_ptr_d    = rx_rd_ptr_q + PTR_W'(rx_pop_c);
      rx_count_d     = rx_count_q + CNT_W'(rx_push_c) - CNT_W'(rx_pop_c);
      ready_upward_d = rx_count_d < FULL_CNT;
   end

   // TX FIFO bookkeeping; head is registered with a bypass for a push into an emptying FIFO
   always_comb begin
      tx_pop_c    = val_out_q && ready_downward;
      tx_wr_ptr_d = tx_wr_ptr_q + PTR_W'(tx_push_c);
      tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(tx_pop_c);
      tx_count_d  = tx_count_q + CNT_W'(tx_push_c) - CNT_W'(tx_pop_c);
      val_out_d   = tx_count_d != CNT_W'(0);
      dout_d      = dout_q;
      if (val_out_d) begin
         if (tx_push_c && (tx_wr_ptr_q == tx_rd_ptr_d)) begin
            dout_d = PAYLOAD_BITS'(mem_wdata);
         end else begin
            dout_d = tx_mem[tx_rd_ptr_d];
         end
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_IDLE;
         mem_ready_q    <= 1'b0;
         mem_rdata_q    <= 32'h0;
         rx_rd_ptr_q    <= '0;
         rx_wr_ptr_q    <= '0;
         rx_count_q     <= '0;
         ready_upward_q <= 1'b0;
         tx_rd_ptr_q    <= '0;
         tx_wr_ptr_q    <= '0;
         tx_count_q     <= '0;
         val_out_q      <= 1'b0;
         dout_q         <= '0;
      end else begin
         state_q        <= state_d;
         mem_ready_q    <= mem_ready_d;
         mem_rdata_q    <= mem_rdata_d;
         rx_rd_ptr_q    <= rx_rd_ptr_d;
         rx_wr_ptr_q    <= rx_wr_ptr_d;
         rx_count_q     <= rx_count_d;
         ready_upward_q <= ready_upward_d;
         tx_rd_ptr_q    <= tx_rd_ptr_d;
         tx_wr_ptr_q    <= tx_wr_ptr_d;
         tx_count_q     <= tx_count_d;
         val_out_q      <= val_out_d;
         dout_q         <= dout_d;
      end
   end

   // FIFO storage; contents are meaningless once the counts are cleared
   always_ff @(posedge clk) begin
      if (rx_push_c) begin
         rx_mem[rx_wr_ptr_q] <= din;
      end
      if (tx_push_c) begin
         tx_mem[tx_wr_ptr_q] <= PAYLOAD_BITS'(mem_wdata);
      end
   end

   assign mem_ready    = mem_ready_q;
   assign mem_rdata    = mem_rdata_q;
   assign sel          = hit_c;
   assign ready_upward = ready_upward_q;
   assign val_out      = val_out_q;
   assign dout         = dout_q;

endmodule

// File: tb/tb_riscv_stream_port.sv
// Bench for riscv_stream_port: register-map table, directed corner cases,
// and a randomized run scored against queue models of both streams.
module tb_riscv_stream_port;

   localparam int unsigned DEPTH = 8;
   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam logic [31:0] A_RX  = BASE;
   localparam logic [31:0] A_TX  = BASE + 32'h4;
   localparam logic [31:0] A_ST  = BASE + 32'h8;
   localparam logic [31:0] A_R3  = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic [3:0]  mem_wstrb = 4'h0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        sel;
   logic [31:0] din = 32'h0;
   logic        val_in = 1'b0;
   logic        ready_upward;
   logic [31:0] dout;
   logic        val_out;
   logic        ready_downward = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: words accepted on a stream but not yet consumed on the other side
   logic [31:0] rx_q[$];
   logic [31:0] tx_q[$];

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        exp_ack;
      logic [31:0] exp_rdata;
      logic        exp_sel;
   } vec_t;

   localparam int NV = 9;
   vec_t vec [NV];

   riscv_stream_port #(
      .PAYLOAD_BITS(32),
      .DEPTH(DEPTH),
      .BASE_ADDR(BASE)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .mem_valid(mem_valid),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready),
      .mem_rdata(mem_rdata),
      .sel(sel),
      .din(din),
      .val_in(val_in),
      .ready_upward(ready_upward),
      .dout(dout),
      .val_out(val_out),
      .ready_downward(ready_downward)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic cpu_start(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      mem_valid = 1'b1;
   endtask

   // lat counts cycles from presenting mem_valid through the cycle mem_ready is seen
   task automatic cpu_wait(input int max_edges, output bit acked, output int lat, output logic [31:0] rdata);
      int edges;
      acked = 1'b0;
      edges = 0;
      rdata = 32'h0;
      while (!acked && edges < max_edges) begin
         @(posedge clk); #1;
         edges++;
         if (mem_ready === 1'b1) begin
            acked = 1'b1;
            rdata = mem_rdata;
         end
      end
      lat = edges + 1;
      if (acked) begin
         @(posedge clk); #1;
         check("mem_ready_one_cycle", 32'(mem_ready), 32'd0);
      end
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
   endtask

   task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                             input int max_edges, output bit acked, output int lat,
                             output logic [31:0] rdata, output logic sel_seen);
      cpu_start(addr, wdata, wstrb);
      #1;
      sel_seen = sel;
      cpu_wait(max_edges, acked, lat, rdata);
   endtask

   task automatic push_word(input logic [31:0] w, input int max_edges, output bit ok);
      din    = w;
      val_in = 1'b1;
      ok     = 1'b0;
      for (int i = 0; i < max_edges && !ok; i++) begin
         if (ready_upward === 1'b1) ok = 1'b1;
         @(posedge clk); #1;
      end
      val_in = 1'b0;
   endtask

   // Scoreboard: stream acceptances feed the models, CPU reads and stream pops drain them
   always @(negedge clk) begin
      if (resetn !== 1'b1) begin
         rx_q.delete();
         tx_q.delete();
      end else begin
         if (val_in && ready_upward) rx_q.push_back(din);
         if (mem_ready && mem_addr[31:4] == BASE[31:4] && mem_addr[3:2] == 2'd0 && mem_wstrb == 4'h0) begin
            if (rx_q.size() == 0) begin
               n_checks++;
               $display("FAIL rx_model: read 0x%08h with no word outstanding", mem_rdata);
            end else begin
               check("rx_model_order", mem_rdata, rx_q.pop_front());
            end
         end
         if (mem_ready && mem_addr[31:4] == BASE[31:4] && mem_addr[3:2] == 2'd1 && mem_wstrb != 4'h0)
            tx_q.push_back(mem_wdata);
         if (val_out && ready_downward) begin
            if (tx_q.size() == 0) begin
               n_checks++;
               $display("FAIL tx_model: popped 0x%08h with no word outstanding", dout);
            end else begin
               check("tx_model_order", dout, tx_q.pop_front());
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acked;
      bit          ok;
      int          lat;
      int          cnt;
      logic [31:0] rd;
      logic        sl;

      vec[0] = '{A_ST, 32'h0,         4'h0, 1'b1, 32'h0, 1'b1};
      vec[1] = '{A_R3, 32'h0,         4'h0, 1'b1, 32'h0, 1'b1};
      vec[2] = '{A_R3, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 1'b1};
      vec[3] = '{A_RX, 32'h5555_AAAA, 4'hF, 1'b1, 32'h0, 1'b1};
      vec[4] = '{A_ST, 32'hFFFF_FFFF, 4'h1, 1'b1, 32'h0, 1'b1};
      vec[5] = '{A_TX, 32'h0,         4'h0, 1'b1, 32'h0, 1'b1};
      vec[6] = '{BASE + 32'h20, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0};
      vec[7] = '{BASE - 32'h10, 32'h1, 4'hF, 1'b0, 32'h0, 1'b0};
      vec[8] = '{A_ST, 32'h0,         4'h0, 1'b1, 32'h0, 1'b1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_ready", 32'(mem_ready), 32'd0);
      check("rst_mem_rdata", mem_rdata, 32'h0);
      check("rst_ready_upward", 32'(ready_upward), 32'd0);
      check("rst_val_out", 32'(val_out), 32'd0);
      check("rst_dout", dout, 32'h0);
      resetn = 1'b1;
      #1;
      check("ready_upward_at_release", 32'(ready_upward), 32'd0);
      @(posedge clk); #1;
      check("ready_upward_after_release", 32'(ready_upward), 32'd1);

      // Register map table with both FIFOs empty
      for (int i = 0; i < NV; i++) begin
         cpu_access(vec[i].addr, vec[i].wdata, vec[i].wstrb, 6, acked, lat, rd, sl);
         check($sformatf("vec%0d_sel", i), 32'(sl), 32'(vec[i].exp_sel));
         check($sformatf("vec%0d_ack", i), 32'(acked), 32'(vec[i].exp_ack));
         if (vec[i].exp_ack) begin
            check($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rdata);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
         end
      end

      // Fill RX to DEPTH without CPU reads
      for (int i = 0; i < 8; i++) begin
         push_word(32'hA0 + 32'(i), 10, ok);
         check($sformatf("rx_fill%0d_accepted", i), 32'(ok), 32'd1);
      end
      check("ready_upward_when_full", 32'(ready_upward), 32'd0);
      cpu_access(A_ST, 32'h0, 4'h0, 6, acked, lat, rd, sl);
      check("status_rx_full", rd, 32'h0000_0008);
      for (int i = 0; i < 8; i++) begin
         cpu_access(A_RX, 32'h0, 4'h0, 6, acked, lat, rd, sl);
         check($sformatf("rx_drain%0d_data", i), rd, 32'hA0 + 32'(i));
         if (i == 0) check("ready_upward_after_pop", 32'(ready_upward), 32'd1);
      end

      // RX read stalls on empty FIFO until a word arrives
      cpu_start(A_RX, 32'h0, 4'h0);
      cnt = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (mem_ready) cnt++;
      end
      check("rx_empty_stall", 32'(cnt), 32'd0);
      din    = 32'h1234_5678;
      val_in = 1'b1;
      @(posedge clk); #1;
      val_in = 1'b0;
      cpu_wait(2, acked, lat, rd);
      check("rx_stall_release_ack", 32'(acked), 32'd1);
      check("rx_stall_release_data", rd, 32'h1234_5678);

      // TX fill, ninth write stalls until one pop
      ready_downward = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cpu_access(A_TX, 32'hB0 + 32'(i), 4'h1, 6, acked, lat, rd, sl);
         check($sformatf("tx_fill%0d_ack", i), 32'(acked), 32'd1);
      end
      cpu_access(A_ST, 32'h0, 4'h0, 6, acked, lat, rd, sl);
      check("status_tx_full", rd, 32'h0000_0800);
      cpu_start(A_TX, 32'hB8, 4'hF);
      cnt = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (mem_ready) cnt++;
      end
      check("tx_full_stall", 32'(cnt), 32'd0);
      check("tx_head_valid", 32'(val_out), 32'd1);
      check("tx_head_data", dout, 32'hB0);
      ready_downward = 1'b1;
      @(posedge clk); #1;
      ready_downward = 1'b0;
      cpu_wait(3, acked, lat, rd);
      check("tx_stall_release_ack", 32'(acked), 32'd1);
      ready_downward = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cnt = 0;
         while (!val_out && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
         end
         check($sformatf("tx_drain%0d_data", k), dout, 32'hB1 + 32'(k));
         @(posedge clk); #1;
      end
      ready_downward = 1'b0;
      check("tx_empty_after_drain", 32'(val_out), 32'd0);

      // Reset asserted while a TX write is stalled and both FIFOs hold data
      for (int i = 0; i < 8; i++) cpu_access(A_TX, 32'hC0 + 32'(i), 4'hF, 6, acked, lat, rd, sl);
      push_word(32'hD0, 10, ok);
      push_word(32'hD1, 10, ok);
      cpu_start(A_TX, 32'hCC, 4'hF);
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check("midrst_mem_ready", 32'(mem_ready), 32'd0);
      check("midrst_val_out", 32'(val_out), 32'd0);
      check("midrst_dout", dout, 32'h0);
      check("midrst_ready_upward", 32'(ready_upward), 32'd0);
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      check("postrst_val_out", 32'(val_out), 32'd0);
      check("postrst_ready_upward", 32'(ready_upward), 32'd1);
      cpu_access(A_ST, 32'h0, 4'h0, 6, acked, lat, rd, sl);
      check("postrst_status", rd, 32'h0);

      // Randomized concurrent traffic in both directions
      fork
         begin : source
            bit pok;
            for (int i = 0; i < 64; i++) begin
               repeat ($urandom % 3) begin
                  @(posedge clk); #1;
               end
               push_word($urandom, 2000, pok);
               check("rand_rx_push", 32'(pok), 32'd1);
            end
         end
         begin : sink
            int pops;
            int cyc;
            pops = 0;
            cyc  = 0;
            while (pops < 64 && cyc < 20000) begin
               ready_downward = ($urandom % 2) == 1;
               if (val_out && ready_downward) pops++;
               @(posedge clk); #1;
               cyc++;
            end
            ready_downward = 1'b0;
            check("rand_tx_pops", 32'(pops), 32'd64);
         end
         begin : cpu
            bit          cack;
            int          clat;
            logic [31:0] crd;
            logic        csl;
            for (int i = 0; i < 64; i++) begin
               cpu_access(A_TX, $urandom, 4'($urandom_range(1, 15)), 2000, cack, clat, crd, csl);
               check("rand_tx_write_ack", 32'(cack), 32'd1);
               cpu_access(A_RX, 32'h0, 4'h0, 2000, cack, clat, crd, csl);
               check("rand_rx_read_ack", 32'(cack), 32'd1);
               if (i % 8 == 7) begin
                  cpu_access(A_ST, 32'h0, 4'h0, 6, cack, clat, crd, csl);
                  check("rand_status_rx_bound", 32'(crd[7:0] <= 8'(DEPTH)), 32'd1);
                  check("rand_status_tx_bound", 32'(crd[15:8] <= 8'(DEPTH)), 32'd1);
                  check("rand_status_upper_zero", 32'(crd[31:16]), 32'd0);
               end
            end
         end
      join
      repeat (4) @(posedge clk);
      #1;
      check("rand_rx_model_empty", 32'(rx_q.size()), 32'd0);
      check("rand_tx_model_empty", 32'(tx_q.size()), 32'd0);
      cpu_access(A_ST, 32'h0, 4'h0, 6, acked, lat, rd, sl);
      check("rand_final_status", rd, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
